// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    // ST_ prefix keeps the state names clear of the PARITY parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic int clks_per_bit(input real sysclk, input real baud);
        return int'(sysclk / baud);
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input.
// Latency: STAGES clocks.
// Backpressure: none; samples every clock.
module synchronizer #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with majority voting, parity/framing/break flags and idle timeout.
// Latency: data_valid one clock after the last stop-bit decision (~4 clocks of pin-to-core delay).
// Backpressure: none; data_valid is a single-cycle pulse the consumer must take.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter real     SYSCLOCK     = 27.0,
    parameter real     BAUDRATE     = 1.0,
    parameter int      DATA_BITS    = 8,
    parameter parity_t PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1,
    parameter int      TIMEOUT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 rx_bsy,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 block_timeout
);

    localparam int CLKS_PER_BIT = clks_per_bit(SYSCLOCK, BAUDRATE);
    localparam int MID          = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDLE_LIMIT   = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W       = $clog2(IDLE_LIMIT + 1);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_S0    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0]  CNT_S1    = CNT_W'(MID);
    localparam logic [CNT_W-1:0]  CNT_DEC   = CNT_W'(MID + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS);
    localparam logic [IDLE_W-1:0] IDLE_END  = IDLE_W'(IDLE_LIMIT - 1);
    localparam logic              LAST_STOP = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_cfg: illegal parameters (CLKS_PER_BIT=%0d)", CLKS_PER_BIT);
    end

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 rx_d_q, rx_d_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 data_valid_q, data_valid_d;
    logic                 break_det_q, break_det_d;
    logic                 timeout_q, timeout_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                 idle_arm_q, idle_arm_d;

    logic fall, at_dec, at_wrap, bit_dec, ferr_now, par_bad, is_break;

    synchronizer #(
        .STAGES  (2),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign fall     = rx_d_q & ~rx_s;
    assign at_dec   = (cnt_q == CNT_DEC);
    assign at_wrap  = (cnt_q == CNT_LAST);
    // Third vote is the live sample, so the decision is ready at MID+1.
    assign bit_dec  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign ferr_now = stop_err_q | ~bit_dec;
    assign par_bad  = (PARITY == PAR_EVEN) ?  (^{shift_q, par_bit_q}) :
                      (PARITY == PAR_ODD)  ? ~(^{shift_q, par_bit_q}) : 1'b0;
    // par_bit_q is never written without parity, so it stays 0 there.
    assign is_break = ferr_now & ~(|shift_q) & ~par_bit_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = at_wrap ? '0 : cnt_q + 1'b1;
        s0_d         = (cnt_q == CNT_S0) ? rx_s : s0_q;
        s1_d         = (cnt_q == CNT_S1) ? rx_s : s1_q;
        rx_d_d       = rx_s;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        stop_idx_d   = stop_idx_q;
        stop_err_d   = stop_err_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        break_det_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (at_dec && bit_dec) begin
                    state_d = ST_IDLE;
                end else if (at_wrap) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (at_dec) begin
                    shift_d   = {bit_dec, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                end
                if (at_wrap && bit_idx_q == IDX_LAST) begin
                    state_d    = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    stop_idx_d = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            ST_PARITY: begin
                if (at_dec) begin
                    par_bit_d = bit_dec;
                end
                if (at_wrap) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_dec) begin
                    if (stop_idx_q == LAST_STOP) begin
                        data_valid_d = 1'b1;
                        data_out_d   = shift_q;
                        parity_err_d = par_bad;
                        frame_err_d  = ferr_now;
                        break_det_d  = is_break;
                        state_d      = is_break ? ST_BREAK : ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                        stop_err_d = ferr_now;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The data_valid cycle is the first IDLE cycle and counts as idle clock 1.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        idle_arm_d = idle_arm_q;
        timeout_d  = 1'b0;
        if (fall) begin
            idle_cnt_d = '0;
            idle_arm_d = 1'b0;
        end else if (data_valid_q) begin
            idle_arm_d = 1'b1;
            idle_cnt_d = (state_q == ST_IDLE) ? IDLE_W'(1) : '0;
        end else if (idle_arm_q && state_q == ST_IDLE) begin
            if (idle_cnt_q == IDLE_END) begin
                timeout_d  = 1'b1;
                idle_arm_d = 1'b0;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            rx_d_q       <= 1'b1;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_idx_q   <= 1'b0;
            stop_err_q   <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            data_valid_q <= 1'b0;
            break_det_q  <= 1'b0;
            timeout_q    <= 1'b0;
            idle_cnt_q   <= '0;
            idle_arm_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            rx_d_q       <= rx_d_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            stop_idx_q   <= stop_idx_d;
            stop_err_q   <= stop_err_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            data_valid_q <= data_valid_d;
            break_det_q  <= break_det_d;
            timeout_q    <= timeout_d;
            idle_cnt_q   <= idle_cnt_d;
            idle_arm_q   <= idle_arm_d;
        end
    end

    assign rx_bsy        = (state_q != ST_IDLE);
    assign data_valid    = data_valid_q;
    assign data_out      = data_out_q;
    assign parity_err    = parity_err_q;
    assign frame_err     = frame_err_q;
    assign break_det     = break_det_q;
    assign block_timeout = timeout_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench: an 8N1 receiver and a 7E1 receiver driven with serial frames,
// outputs compared against frame-level expectations computed here.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CPB    = 27;
    localparam int TO_CLK = 4 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_a, rx_b;

    logic       a_bsy, a_dv, a_pe, a_fe, a_brk, a_to;
    logic [7:0] a_data;
    logic       b_bsy, b_dv, b_pe, b_fe, b_brk, b_to;
    logic [6:0] b_data;

    always #5 clk = ~clk;

    uart_rx_cfg u_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_bsy(a_bsy), .data_valid(a_dv),
        .data_out(a_data), .parity_err(a_pe), .frame_err(a_fe), .break_det(a_brk),
        .block_timeout(a_to)
    );

    uart_rx_cfg #(
        .DATA_BITS(7), .PARITY(PAR_EVEN)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_bsy(b_bsy), .data_valid(b_dv),
        .data_out(b_data), .parity_err(b_pe), .frame_err(b_fe), .break_det(b_brk),
        .block_timeout(b_to)
    );

    typedef struct {
        logic [8:0]  d;
        logic        pe;
        logic        fe;
        logic        brk;
        int unsigned cyc;
    } rec_t;

    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    rec_t        q_a[$];
    rec_t        q_b[$];
    int unsigned to_a[$];
    int          brk_a_cnt = 0;
    rec_t        r_a, r_b;
    int          n_assert = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_dv === 1'b1) begin
            r_a.d = {1'b0, a_data}; r_a.pe = a_pe; r_a.fe = a_fe; r_a.brk = a_brk; r_a.cyc = cyc;
            q_a.push_back(r_a);
        end
        if (b_dv === 1'b1) begin
            r_b.d = {2'b00, b_data}; r_b.pe = b_pe; r_b.fe = b_fe; r_b.brk = b_brk; r_b.cyc = cyc;
            q_b.push_back(r_b);
        end
        if (a_to === 1'b1) to_a.push_back(cyc);
        if (a_brk === 1'b1) brk_a_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // One bit per CPB clocks; gbit selects a frame bit to receive a 1-clock inversion mid-bit.
    task automatic send_frame(input bit sel, input int nd, input logic [8:0] data,
                              input bit use_par, input logic pbit, input logic stop_v,
                              input int gbit);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(data[i]);
        if (use_par) bits.push_back(pbit);
        bits.push_back(stop_v);
        foreach (bits[j]) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (j == 0 && k == 0) start_cyc = cyc;
                drive(sel, (gbit == j && k == 14) ? ~bits[j] : bits[j]);
            end
        end
    endtask

    // Frame end time from the pin start edge, from the frame length in bit-times.
    function automatic int exp_latency(input int nd, input int np, input int ns);
        real t;
        t = (1 + nd + np + ns - 0.5) * CPB + ((CPB / 2 + 1) - CPB / 2.0) + 4.0;
        return int'(t);
    endfunction

    function automatic logic even_par_err(input logic [8:0] d, input int nd, input logic pbit);
        int ones;
        ones = int'(pbit);
        for (int i = 0; i < nd; i++) ones += int'(d[i]);
        return (ones % 2) != 0;
    endfunction

    task automatic expect_frame(input bit sel, input string tag, input logic [8:0] d,
                                input logic pe, input logic fe, input logic brk,
                                input int lat_exp);
        rec_t r;
        int   n;
        n = sel ? q_b.size() : q_a.size();
        chk({tag, "_count"}, n, 1);
        if (n > 0) begin
            if (sel) r = q_b.pop_front();
            else     r = q_a.pop_front();
            chk({tag, "_data"}, {23'd0, r.d}, {23'd0, d});
            chk({tag, "_perr"}, {31'd0, r.pe}, {31'd0, pe});
            chk({tag, "_ferr"}, {31'd0, r.fe}, {31'd0, fe});
            chk({tag, "_brk"}, {31'd0, r.brk}, {31'd0, brk});
            chk_win({tag, "_lat"}, int'(r.cyc - start_cyc), lat_exp - 2, lat_exp + 2);
        end
        if (sel) q_b.delete();
        else     q_a.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bsy"},  {31'd0, a_bsy}, 0);
        chk({tag, "_dv"},   {31'd0, a_dv},  0);
        chk({tag, "_data"}, {24'd0, a_data}, 0);
        chk({tag, "_perr"}, {31'd0, a_pe},  0);
        chk({tag, "_ferr"}, {31'd0, a_fe},  0);
        chk({tag, "_brk"},  {31'd0, a_brk}, 0);
        chk({tag, "_to"},   {31'd0, a_to},  0);
        chk({tag, "_b_data"}, {25'd0, b_data}, 0);
    endtask

    initial begin
        logic [8:0] d;
        logic       pb;
        rec_t       r0, r1;
        int         lat_a, lat_b;
        int         nb2b;

        lat_a = exp_latency(8, 0, 1);
        lat_b = exp_latency(7, 1, 1);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        idle(5);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(200);
        chk("no_timeout_after_reset", to_a.size(), 0);

        send_frame(0, 8, 9'h0A5, 0, 1'b0, 1'b1, -1);
        idle(CPB);
        expect_frame(0, "a5", 9'h0A5, 1'b0, 1'b0, 1'b0, lat_a);
        chk("a5_bsy_after", {31'd0, a_bsy}, 0);

        send_frame(1, 7, 9'h041, 1, 1'b0, 1'b1, -1);
        idle(CPB);
        expect_frame(1, "p41_good", 9'h041, 1'b0, 1'b0, 1'b0, lat_b);
        send_frame(1, 7, 9'h041, 1, 1'b1, 1'b1, -1);
        idle(CPB);
        expect_frame(1, "p41_bad", 9'h041, 1'b1, 1'b0, 1'b0, lat_b);

        send_frame(0, 8, 9'h03C, 0, 1'b0, 1'b0, -1);
        rx_a = 1'b1;
        idle(CPB);
        expect_frame(0, "3c_ferr", 9'h03C, 1'b0, 1'b1, 1'b0, lat_a);

        // 20 bit-times low: a full all-zero frame plus ten more bit-times.
        brk_a_cnt = 0;
        send_frame(0, 8, 9'h000, 0, 1'b0, 1'b0, -1);
        idle(10 * CPB);
        expect_frame(0, "break", 9'h000, 1'b0, 1'b1, 1'b1, lat_a);
        chk("break_bsy_line_low", {31'd0, a_bsy}, 1);
        rx_a = 1'b1;
        idle(CPB);
        chk("break_bsy_released", {31'd0, a_bsy}, 0);
        chk("break_pulses", brk_a_cnt, 1);
        chk("break_no_extra_dv", q_a.size(), 0);

        rx_a = 1'b0;
        idle(1);
        rx_a = 1'b1;
        idle(5);
        chk("glitch1_bsy_rise", {31'd0, a_bsy}, 1);
        idle(16);
        chk("glitch1_bsy_low", {31'd0, a_bsy}, 0);
        idle(CPB);
        rx_a = 1'b0;
        idle(10);
        rx_a = 1'b1;
        idle(12);
        chk("glitch10_bsy_low", {31'd0, a_bsy}, 0);
        idle(11 * CPB);
        chk("glitch_no_dv", q_a.size(), 0);

        send_frame(0, 8, 9'h05A, 0, 1'b0, 1'b1, 1);
        idle(CPB);
        expect_frame(0, "mid_glitch", 9'h05A, 1'b0, 1'b0, 1'b0, lat_a);

        for (int i = 0; i < 6; i++) begin
            d = 9'($urandom_range(0, 255));
            send_frame(0, 8, d, 0, 1'b0, 1'b1, -1);
            idle(3);
            expect_frame(0, "rand_a", d, 1'b0, 1'b0, 1'b0, lat_a);
            d  = 9'($urandom_range(0, 127));
            pb = 1'($urandom_range(0, 1));
            send_frame(1, 7, d, 1, pb, 1'b1, -1);
            idle(3);
            expect_frame(1, "rand_b", d, even_par_err(d, 7, pb), 1'b0, 1'b0, lat_b);
        end

        idle(200);
        to_a.delete();
        q_a.delete();
        send_frame(0, 8, 9'h000, 0, 1'b0, 1'b1, -1);
        send_frame(0, 8, 9'h0FF, 0, 1'b0, 1'b1, -1);
        idle(250);
        nb2b = q_a.size();
        chk("b2b_count", nb2b, 2);
        chk("b2b_timeouts", to_a.size(), 1);
        if (nb2b == 2) begin
            r0 = q_a.pop_front();
            r1 = q_a.pop_front();
            chk("b2b_first", {23'd0, r0.d}, 32'h00);
            chk("b2b_second", {23'd0, r1.d}, 32'hFF);
            if (to_a.size() > 0) chk("timeout_delay", to_a[0] - r1.cyc, TO_CLK);
        end
        idle(500);
        chk("timeout_once", to_a.size(), 1);
        chk("data_hold", {24'd0, a_data}, 32'hFF);

        fork
            send_frame(0, 8, 9'h055, 0, 1'b0, 1'b1, -1);
            begin
                idle(5 * CPB + 13);
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("midrst");
            end
        join
        rx_a = 1'b1;
        idle(10);
        rst_n = 1'b1;
        idle(CPB);
        chk("midrst_no_dv", q_a.size(), 0);
        send_frame(0, 8, 9'h055, 0, 1'b0, 1'b1, -1);
        idle(CPB);
        expect_frame(0, "after_rst", 9'h055, 1'b0, 1'b0, 1'b0, lat_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
